// File: rtl/pipe_hazard_ctrl_if.sv
// Control bundle between the pipeline datapath and the hazard sequencer.
// The datapath takes the master side. The sequencer takes the slave side.
interface pipe_hazard_ctrl_if;
    logic [0:5]  id_src_a;
    logic [0:5]  id_src_b;
    logic        id_use_a;
    logic        id_use_b;
    logic [0:5]  ex_dest;
    logic        ex_reg_write;
    logic        ex_mc_op;
    logic [0:5]  mem_dest;
    logic        mem_reg_write;
    logic [0:5]  wb_dest;
    logic        wb_reg_write;
    logic        mem_redirect;
    logic        clear_stats;
    logic        stall_if;
    logic        bubble_ex;
    logic        hold_ex;
    logic        flush_id;
    logic        flush_ex;
    logic        flush_mem;
    logic        mc_busy;
    logic [0:15] stall_count;
    logic [0:15] flush_count;

    modport master (
        output id_src_a, id_src_b, id_use_a, id_use_b,
        output ex_dest, ex_reg_write, ex_mc_op,
        output mem_dest, mem_reg_write, wb_dest, wb_reg_write,
        output mem_redirect, clear_stats,
        input  stall_if, bubble_ex, hold_ex, flush_id, flush_ex, flush_mem,
        input  mc_busy, stall_count, flush_count
    );

    modport slave (
        input  id_src_a, id_src_b, id_use_a, id_use_b,
        input  ex_dest, ex_reg_write, ex_mc_op,
        input  mem_dest, mem_reg_write, wb_dest, wb_reg_write,
        input  mem_redirect, clear_stats,
        output stall_if, bubble_ex, hold_ex, flush_id, flush_ex, flush_mem,
        output mc_busy, stall_count, flush_count
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: handles RAW stall/bubble, multi-cycle EX hold and redirect flush.
// It also keeps saturating stall and flush statistics counters.
module pipe_hazard_ctrl #(
    parameter int unsigned MC_LATENCY = 4,
    parameter bit          RF_BYPASS  = 1'b0
) (
    input  logic               clock,
    input  logic               reset,
    pipe_hazard_ctrl_if.slave  bus
);
    typedef enum logic {RUN = 1'b0, MC_BUSY = 1'b1} state_e;

    localparam logic [3:0] MC_LOAD = 4'(MC_LATENCY - 2);

    state_e      state_q, state_d;
    logic [3:0]  mc_cnt_q, mc_cnt_d;
    logic [0:15] stall_count_q, stall_count_d;
    logic [0:15] flush_count_q, flush_count_d;

    logic        stall_int, bubble_int, hold_int, flush_int;
    logic        raw;
    logic [0:5]  wr_dest [3];
    logic [2:0]  wr_en;
    logic [2:0]  hit;

    function automatic logic tag_hit(input logic use_src, input logic [0:5] src,
                                     input logic wr, input logic [0:5] dst);
        return use_src && wr && (src == dst) && (src != 6'b000000);
    endfunction

    // Writer 0 is EX, 1 is MEM, 2 is WB. WB is ignored when the file forwards its own write.
    assign wr_dest[0] = bus.ex_dest;
    assign wr_dest[1] = bus.mem_dest;
    assign wr_dest[2] = bus.wb_dest;
    assign wr_en      = {bus.wb_reg_write && !RF_BYPASS, bus.mem_reg_write, bus.ex_reg_write};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_hit
            assign hit[gi] = tag_hit(bus.id_use_a, bus.id_src_a, wr_en[gi], wr_dest[gi]) ||
                             tag_hit(bus.id_use_b, bus.id_src_b, wr_en[gi], wr_dest[gi]);
        end
    endgenerate

    assign raw = |hit;

    always_comb begin
        state_d    = state_q;
        mc_cnt_d   = mc_cnt_q;
        stall_int  = 1'b0;
        bubble_int = 1'b0;
        hold_int   = 1'b0;
        flush_int  = 1'b0;
        if (bus.mem_redirect) begin
            flush_int = 1'b1;
            state_d   = RUN;
            mc_cnt_d  = 4'd0;
        end else if (state_q == RUN && bus.ex_mc_op) begin
            hold_int  = 1'b1;
            stall_int = 1'b1;
            mc_cnt_d  = MC_LOAD;
            state_d   = MC_BUSY;
        end else if (state_q == MC_BUSY && mc_cnt_q != 4'd0) begin
            hold_int  = 1'b1;
            stall_int = 1'b1;
            mc_cnt_d  = mc_cnt_q - 4'd1;
        end else begin
            // Release cycle of a multi-cycle op behaves like a normal RUN cycle.
            state_d = RUN;
            if (raw) begin
                stall_int  = 1'b1;
                bubble_int = 1'b1;
            end
        end
    end

    always_comb begin
        stall_count_d = stall_count_q;
        flush_count_d = flush_count_q;
        if (bus.clear_stats) begin
            stall_count_d = 16'h0000;
            flush_count_d = 16'h0000;
        end else begin
            if (stall_int && stall_count_q != 16'hFFFF)
                stall_count_d = stall_count_q + 16'h0001;
            if (flush_int && flush_count_q != 16'hFFFF)
                flush_count_d = flush_count_q + 16'h0001;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= RUN;
            mc_cnt_q      <= 4'd0;
            stall_count_q <= 16'h0000;
            flush_count_q <= 16'h0000;
        end else begin
            state_q       <= state_d;
            mc_cnt_q      <= mc_cnt_d;
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    // Reset forces the pipeline to flush without waiting for a clock edge.
    assign bus.stall_if    = reset && stall_int;
    assign bus.bubble_ex   = reset && bubble_int;
    assign bus.hold_ex     = reset && hold_int;
    assign bus.flush_id    = !reset || flush_int;
    assign bus.flush_ex    = !reset || flush_int;
    assign bus.flush_mem   = !reset || flush_int;
    assign bus.mc_busy     = reset && (state_q == MC_BUSY);
    assign bus.stall_count = stall_count_q;
    assign bus.flush_count = flush_count_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: table vectors, multi-cycle/redirect sequences, counters, async reset.
// Two instances differ only in RF_BYPASS and receive identical stimulus.
module tb_pipe_hazard_ctrl;
    logic clock;
    logic reset;

    logic [0:5] id_src_a, id_src_b, ex_dest, mem_dest, wb_dest;
    logic id_use_a, id_use_b, ex_reg_write, ex_mc_op, mem_reg_write, wb_reg_write;
    logic mem_redirect, clear_stats;

    pipe_hazard_ctrl_if bus0 ();
    pipe_hazard_ctrl_if bus1 ();

    pipe_hazard_ctrl #(.MC_LATENCY(4), .RF_BYPASS(1'b0)) dut0 (.clock(clock), .reset(reset), .bus(bus0));
    pipe_hazard_ctrl #(.MC_LATENCY(4), .RF_BYPASS(1'b1)) dut1 (.clock(clock), .reset(reset), .bus(bus1));

    assign bus0.id_src_a = id_src_a;          assign bus1.id_src_a = id_src_a;
    assign bus0.id_src_b = id_src_b;          assign bus1.id_src_b = id_src_b;
    assign bus0.id_use_a = id_use_a;          assign bus1.id_use_a = id_use_a;
    assign bus0.id_use_b = id_use_b;          assign bus1.id_use_b = id_use_b;
    assign bus0.ex_dest = ex_dest;            assign bus1.ex_dest = ex_dest;
    assign bus0.ex_reg_write = ex_reg_write;  assign bus1.ex_reg_write = ex_reg_write;
    assign bus0.ex_mc_op = ex_mc_op;          assign bus1.ex_mc_op = ex_mc_op;
    assign bus0.mem_dest = mem_dest;          assign bus1.mem_dest = mem_dest;
    assign bus0.mem_reg_write = mem_reg_write; assign bus1.mem_reg_write = mem_reg_write;
    assign bus0.wb_dest = wb_dest;            assign bus1.wb_dest = wb_dest;
    assign bus0.wb_reg_write = wb_reg_write;  assign bus1.wb_reg_write = wb_reg_write;
    assign bus0.mem_redirect = mem_redirect;  assign bus1.mem_redirect = mem_redirect;
    assign bus0.clear_stats = clear_stats;    assign bus1.clear_stats = clear_stats;

    // Output vector order: stall_if, bubble_ex, hold_ex, flush_id, flush_ex, flush_mem, mc_busy
    logic [6:0] o0, o1;
    assign o0 = {bus0.stall_if, bus0.bubble_ex, bus0.hold_ex, bus0.flush_id, bus0.flush_ex, bus0.flush_mem, bus0.mc_busy};
    assign o1 = {bus1.stall_if, bus1.bubble_ex, bus1.hold_ex, bus1.flush_id, bus1.flush_ex, bus1.flush_mem, bus1.mc_busy};

    localparam logic [6:0] O_NONE  = 7'b0000000;
    localparam logic [6:0] O_RAW   = 7'b1100000;
    localparam logic [6:0] O_HOLD  = 7'b1010000;
    localparam logic [6:0] O_HOLDB = 7'b1010001;
    localparam logic [6:0] O_BUSY  = 7'b0000001;
    localparam logic [6:0] O_FLUSH = 7'b0001110;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    logic [15:0] stall_exp = 16'h0000;
    logic [15:0] flush_exp = 16'h0000;

    typedef struct {
        string      tag;
        logic [6:0] e0;
        logic [6:0] e1;
    } sb_t;
    sb_t sb_q[$];

    typedef struct {
        string      tag;
        logic [0:5] sa, sb;
        logic       ua, ub;
        logic [0:5] ed;
        logic       ew;
        logic [0:5] md;
        logic       mw;
        logic [0:5] wd;
        logic       ww;
        logic       r0, r1;
    } vec_t;
    vec_t vecs[11];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        id_src_a = '0; id_src_b = '0; id_use_a = 1'b0; id_use_b = 1'b0;
        ex_dest = '0; ex_reg_write = 1'b0; ex_mc_op = 1'b0;
        mem_dest = '0; mem_reg_write = 1'b0; wb_dest = '0; wb_reg_write = 1'b0;
        mem_redirect = 1'b0; clear_stats = 1'b0;
    endtask

    // Push expectation, compare combinational outputs at negedge, then counters after the edge.
    task automatic cycle_check(input string tag, input logic [6:0] e0, input logic [6:0] e1);
        sb_t s;
        s.tag = tag; s.e0 = e0; s.e1 = e1;
        sb_q.push_back(s);
        @(negedge clock);
        s = sb_q.pop_front();
        chk({s.tag, "/outs_nobyp"}, {9'd0, o0}, {9'd0, s.e0});
        chk({s.tag, "/outs_byp"}, {9'd0, o1}, {9'd0, s.e1});
        $display("txn %s outs0=%b outs1=%b stall_cnt=%0d flush_cnt=%0d", s.tag, o0, o1,
                 bus0.stall_count, bus0.flush_count);
        @(posedge clock);
        if (clear_stats) begin
            stall_exp = 16'h0000;
            flush_exp = 16'h0000;
        end else begin
            if (s.e0[6] && stall_exp != 16'hFFFF) stall_exp = stall_exp + 16'h0001;
            if (mem_redirect && flush_exp != 16'hFFFF) flush_exp = flush_exp + 16'h0001;
        end
        #1;
        chk({s.tag, "/stall_count"}, bus0.stall_count, stall_exp);
        chk({s.tag, "/flush_count"}, bus0.flush_count, flush_exp);
    endtask

    initial begin
        vecs[0]  = '{"ex_raw",     6'h03, 6'h00, 1, 0, 6'h03, 1, 6'h00, 0, 6'h00, 0, 1, 1};
        vecs[1]  = '{"r0_never",   6'h00, 6'h00, 1, 0, 6'h00, 1, 6'h00, 0, 6'h00, 0, 0, 0};
        vecs[2]  = '{"fp_vs_gp",   6'h03, 6'h00, 1, 0, 6'h23, 1, 6'h00, 0, 6'h00, 0, 0, 0};
        vecs[3]  = '{"gp_vs_fp",   6'h23, 6'h00, 1, 0, 6'h03, 1, 6'h00, 0, 6'h00, 0, 0, 0};
        vecs[4]  = '{"use_off",    6'h03, 6'h03, 0, 0, 6'h03, 1, 6'h00, 0, 6'h00, 0, 0, 0};
        vecs[5]  = '{"ex_nowr",    6'h03, 6'h00, 1, 0, 6'h03, 0, 6'h00, 0, 6'h00, 0, 0, 0};
        vecs[6]  = '{"mem_b_fp",   6'h00, 6'h25, 0, 1, 6'h00, 0, 6'h25, 1, 6'h00, 0, 1, 1};
        vecs[7]  = '{"wb_a",       6'h07, 6'h00, 1, 0, 6'h00, 0, 6'h00, 0, 6'h07, 1, 1, 0};
        vecs[8]  = '{"wb_b_fp",    6'h00, 6'h3F, 0, 1, 6'h00, 0, 6'h00, 0, 6'h3F, 1, 1, 0};
        vecs[9]  = '{"fp_diff",    6'h21, 6'h00, 1, 0, 6'h22, 1, 6'h00, 0, 6'h00, 0, 0, 0};
        vecs[10] = '{"mem_nowr",   6'h11, 6'h00, 1, 0, 6'h00, 0, 6'h11, 0, 6'h12, 1, 0, 0};

        clear_inputs();
        reset = 1'b0;
        #2;
        chk("reset/outs_nobyp", {9'd0, o0}, {9'd0, O_FLUSH});
        chk("reset/outs_byp", {9'd0, o1}, {9'd0, O_FLUSH});
        chk("reset/stall_count", bus0.stall_count, 16'h0000);
        chk("reset/flush_count", bus0.flush_count, 16'h0000);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;

        for (int i = 0; i < 11; i++) begin
            id_src_a = vecs[i].sa; id_src_b = vecs[i].sb;
            id_use_a = vecs[i].ua; id_use_b = vecs[i].ub;
            ex_dest = vecs[i].ed; ex_reg_write = vecs[i].ew;
            mem_dest = vecs[i].md; mem_reg_write = vecs[i].mw;
            wb_dest = vecs[i].wd; wb_reg_write = vecs[i].ww;
            cycle_check(vecs[i].tag, vecs[i].r0 ? O_RAW : O_NONE, vecs[i].r1 ? O_RAW : O_NONE);
        end
        clear_inputs();

        // Multi-cycle op whose consumer sits in ID: held 3 cycles, bubbled on release.
        ex_dest = 6'h05; ex_reg_write = 1'b1; ex_mc_op = 1'b1; id_src_a = 6'h05; id_use_a = 1'b1;
        cycle_check("mc1_c1", O_HOLD, O_HOLD);
        cycle_check("mc1_c2", O_HOLDB, O_HOLDB);
        cycle_check("mc1_c3", O_HOLDB, O_HOLDB);
        cycle_check("mc1_c4_release_raw", O_RAW | O_BUSY, O_RAW | O_BUSY);
        ex_mc_op = 1'b0; id_use_a = 1'b0;
        cycle_check("mc1_after", O_NONE, O_NONE);

        // Back-to-back ops, then a redirect on the second MC_BUSY cycle of the second op.
        ex_mc_op = 1'b1;
        cycle_check("b2b_c1", O_HOLD, O_HOLD);
        cycle_check("b2b_c2", O_HOLDB, O_HOLDB);
        cycle_check("b2b_c3", O_HOLDB, O_HOLDB);
        cycle_check("b2b_c4", O_BUSY, O_BUSY);
        cycle_check("b2b_retrigger", O_HOLD, O_HOLD);
        cycle_check("b2b_busy1", O_HOLDB, O_HOLDB);
        mem_redirect = 1'b1;
        cycle_check("redirect_mid_hold", O_FLUSH | O_BUSY, O_FLUSH | O_BUSY);
        mem_redirect = 1'b0; ex_mc_op = 1'b0;
        cycle_check("after_redirect", O_NONE, O_NONE);

        // Priority: redirect beats multi-cycle and raw together.
        id_src_a = 6'h03; id_use_a = 1'b1; ex_dest = 6'h03; ex_reg_write = 1'b1;
        ex_mc_op = 1'b1; mem_redirect = 1'b1;
        cycle_check("priority_all", O_FLUSH, O_FLUSH);
        ex_mc_op = 1'b0; mem_redirect = 1'b0;
        cycle_check("priority_raw_only", O_RAW, O_RAW);

        // Clear wins over an increment.
        clear_stats = 1'b1;
        cycle_check("clear_with_raw", O_RAW, O_RAW);
        clear_stats = 1'b0;
        cycle_check("raw_after_clear", O_RAW, O_RAW);

        // Saturation: hold raw well past 65535 stall cycles.
        repeat (65540) @(posedge clock);
        #1;
        stall_exp = 16'hFFFF;
        chk("saturate/stall_count", bus0.stall_count, stall_exp);
        cycle_check("saturate_hold", O_RAW, O_RAW);
        clear_stats = 1'b1;
        cycle_check("clear_after_sat", O_RAW, O_RAW);
        clear_inputs();

        // Async reset asserted while in MC_BUSY.
        ex_mc_op = 1'b1;
        cycle_check("pre_reset_c1", O_HOLD, O_HOLD);
        cycle_check("pre_reset_c2", O_HOLDB, O_HOLDB);
        #2;
        reset = 1'b0;
        #1;
        chk("async_reset/outs_nobyp", {9'd0, o0}, {9'd0, O_FLUSH});
        chk("async_reset/outs_byp", {9'd0, o1}, {9'd0, O_FLUSH});
        chk("async_reset/stall_count", bus0.stall_count, 16'h0000);
        stall_exp = 16'h0000;
        flush_exp = 16'h0000;
        @(negedge clock);
        reset = 1'b1;
        ex_mc_op = 1'b0;
        @(posedge clock);
        #1;
        cycle_check("post_reset", O_NONE, O_NONE);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
